seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 9 +
 rtl/cond_negate.sv | 10 +
 rtl/seq_multiplier.sv | 61 ++++++
 tb/tb_seq_multiplier.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default operand width for the sequential multiplier
package mult_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int WIDTH_DEFAULT = 8;
endpackage

// File: rtl/cond_negate.sv
// cond_negate: passes the value through or returns its two's complement when neg is set
module cond_negate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);
    assign result = neg ? -value : value;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, one multiplier bit per cycle, signed via sign-magnitude
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] mag_a, mag_b, mplier;
    logic [2*WIDTH-1:0] mcand, acc, acc_nx, result;
    logic [CW-1:0] cnt;
    logic neg, last;
    cond_negate #(.WIDTH(WIDTH)) u_mag_a (.value(a), .neg(is_signed & a[WIDTH-1]), .result(mag_a));
    cond_negate #(.WIDTH(WIDTH)) u_mag_b (.value(b), .neg(is_signed & b[WIDTH-1]), .result(mag_b));
    // the final partial product is folded in on the same edge that loads product
    assign acc_nx = acc + (mplier[0] ? mcand : '0);
    cond_negate #(.WIDTH(2*WIDTH)) u_sign (.value(acc_nx), .neg(neg), .result(result));
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state == CALC;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        state_nx = (state == CALC) ? (last ? DONE : CALC) : (start ? CALC : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (state == CALC) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) product <= result;
        end else if (start) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized and directed scoreboard bench against an arithmetic reference model
module tb_seq_multiplier;
    localparam int W = 8;
    typedef struct {
        logic [2*W-1:0] p;
        int             e;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done;
    logic [2*W-1:0] product;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0, kstart = -100, kend = -100;
    logic [2*W-1:0] last_prod = '0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(bit sg, logic [W-1:0] x, logic [W-1:0] y);
        longint p;
        p = sg ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // monitor: runs just after each rising edge; cyc is the number of edges seen
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q.delete();
            last_prod = '0;
            if (kend > cyc) kend = cyc;
        end
        chk("busy", busy, cyc >= kstart && cyc < kend);
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("product", product, e.p);
                chk("done_edge", cyc + 1, e.e);
                last_prod = e.p;
            end
        end else begin
            chk("product_hold", product, last_prod);
        end
    end

    task automatic go(bit sg, logic [W-1:0] x, logic [W-1:0] y);
        exp_t e;
        start = 1'b1;
        is_signed = sg;
        a = x;
        b = y;
        kstart = cyc + 1;
        kend = kstart + W;
        e.p = ref_mul(sg, x, y);
        e.e = kstart + W + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        go(0, 8'h04, 8'h02);
        wait_done();
        @(negedge clk);
        go(0, 8'h0C, 8'h03);
        wait_done();
        go(0, 8'hFF, 8'hFF);
        wait_done();
        go(1, 8'hFB, 8'h03);
        wait_done();
        go(1, 8'h80, 8'h80);
        wait_done();
        go(1, 8'h00, 8'hFF);
        wait_done();
        @(negedge clk);
        go(0, 8'h04, 8'h05);
        @(negedge clk);
        start = 1'b1;
        a = 8'h07;
        b = 8'h09;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        go(0, 8'h33, 8'h11);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 8'h55;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        go(1, 8'h9C, 8'h7F);
        wait_done();
        for (int n = 0; n < 40; n++) begin
            go($urandom_range(0, 1), W'($urandom), W'($urandom));
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
